// File: rtl/router_pkt_reg_if.sv
// router_pkt_reg_if: source, FIFO and controller signals of the packet register stage
interface router_pkt_reg_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              pkt_valid;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              fifo_full;
    logic              rst_int_reg;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic [ADDR_W-1:0] header_addr;
    logic              header_valid;
    logic              parity_done;
    logic              low_pkt_valid;
    logic              err;
    logic              len_err;
    modport master (
        output pkt_valid, data_in, fifo_full, rst_int_reg,
        input  busy, dout, dout_valid, header_addr, header_valid, parity_done, low_pkt_valid, err, len_err
    );
    modport slave (
        input  pkt_valid, data_in, fifo_full, rst_int_reg,
        output busy, dout, dout_valid, header_addr, header_valid, parity_done, low_pkt_valid, err, len_err
    );
endinterface

// File: rtl/router_pkt_reg.sv
// router_pkt_reg: packet register stage with skid buffer and running parity; ROUTER_LEN_CHECK_EN adds payload length check
module router_pkt_reg #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 2,
    parameter int HOLD_DEPTH = 4
) (
    input  logic            clock_i,
    input  logic            resetn_i,
    router_pkt_reg_if.slave bus
);
    localparam int CNT_W = $clog2(HOLD_DEPTH + 1);
    localparam int PTR_W = $clog2(HOLD_DEPTH);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [DATA_W-1:0] mem_q [HOLD_DEPTH];
    logic [DATA_W-1:0] dout_q, dout_d, parity_q, parity_d;
    logic [ADDR_W-1:0] header_addr_q, header_addr_d;
    logic              dout_valid_q, dout_valid_d, header_valid_q, header_valid_d;
    logic              parity_done_q, parity_done_d, low_pkt_valid_q, low_pkt_valid_d, err_q, err_d;
    logic              busy, accept, hdr_acc, pay_acc, par_acc, push, pop, direct;
    assign busy    = (count_q == CNT_W'(HOLD_DEPTH)) || state_q == DRAIN;
    assign accept  = !busy && (state_q == IDLE ? bus.pkt_valid : state_q == LOAD);
    assign hdr_acc = accept && state_q == IDLE;
    assign pay_acc = accept && state_q == LOAD && bus.pkt_valid;
    assign par_acc = accept && state_q == LOAD && !bus.pkt_valid;
    assign pop     = !bus.fifo_full && count_q != '0;
    assign push    = accept && (bus.fifo_full || count_q != '0);
    assign direct  = accept && !bus.fifo_full && count_q == '0;
    // next state of the FSM, buffer pointers, output byte and packet status
    always_comb begin
        state_d         = hdr_acc ? LOAD : par_acc ? DRAIN : (state_q == DRAIN && count_q == '0) ? IDLE : state_q;
        count_d         = count_q + CNT_W'(push) - CNT_W'(pop);
        head_d          = pop ? (head_q == PTR_W'(HOLD_DEPTH - 1) ? '0 : head_q + 1'b1) : head_q;
        tail_d          = push ? (tail_q == PTR_W'(HOLD_DEPTH - 1) ? '0 : tail_q + 1'b1) : tail_q;
        dout_d          = pop ? mem_q[head_q] : direct ? bus.data_in : dout_q;
        dout_valid_d    = pop || direct;
        header_addr_d   = hdr_acc ? bus.data_in[ADDR_W-1:0] : header_addr_q;
        header_valid_d  = hdr_acc;
        parity_d        = hdr_acc ? bus.data_in : pay_acc ? parity_q ^ bus.data_in : parity_q;
        parity_done_d   = hdr_acc ? 1'b0 : par_acc ? 1'b1 : parity_done_q;
        err_d           = hdr_acc ? 1'b0 : par_acc ? (parity_q != bus.data_in) : err_q;
        low_pkt_valid_d = bus.rst_int_reg ? 1'b0 : par_acc ? 1'b1 : low_pkt_valid_q;
    end
    // state and status registers; reset aborts a packet and forgets any buffered bytes
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q         <= IDLE;
            count_q         <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            dout_q          <= '0;
            dout_valid_q    <= 1'b0;
            header_addr_q   <= '0;
            header_valid_q  <= 1'b0;
            parity_q        <= '0;
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            dout_q          <= dout_d;
            dout_valid_q    <= dout_valid_d;
            header_addr_q   <= header_addr_d;
            header_valid_q  <= header_valid_d;
            parity_q        <= parity_d;
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
            err_q           <= err_d;
        end
    end
    // skid storage; contents are only meaningful between tail and head
    always_ff @(posedge clock_i) begin
        if (push) mem_q[tail_q] <= bus.data_in;
    end
`ifdef ROUTER_LEN_CHECK_EN
    localparam int LEN_W = DATA_W - ADDR_W;
    logic [LEN_W-1:0] len_cnt_q, len_cnt_d, len_exp_q, len_exp_d;
    logic             len_err_q, len_err_d;
    // saturating payload count compared against the header length on the parity byte
    always_comb begin
        len_exp_d = hdr_acc ? bus.data_in[DATA_W-1:ADDR_W] : len_exp_q;
        len_cnt_d = hdr_acc ? '0 : (pay_acc && len_cnt_q != '1) ? len_cnt_q + 1'b1 : len_cnt_q;
        len_err_d = hdr_acc ? 1'b0 : par_acc ? (len_cnt_q != len_exp_q) : len_err_q;
    end
    // length-check registers
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            len_cnt_q <= '0;
            len_exp_q <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_cnt_q <= len_cnt_d;
            len_exp_q <= len_exp_d;
            len_err_q <= len_err_d;
        end
    end
    assign bus.len_err = len_err_q;
`else
    assign bus.len_err = 1'b0;
`endif
    assign bus.busy          = busy;
    assign bus.dout          = dout_q;
    assign bus.dout_valid    = dout_valid_q;
    assign bus.header_addr   = header_addr_q;
    assign bus.header_valid  = header_valid_q;
    assign bus.parity_done   = parity_done_q;
    assign bus.low_pkt_valid = low_pkt_valid_q;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_router_pkt_reg.sv
// tb_router_pkt_reg: queue-based reference model with per-cycle compare plus directed packets
module tb_router_pkt_reg;
`ifdef ROUTER_LEN_CHECK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif
    localparam int DEPTH = 4;
    logic clk = 1'b0, resetn = 1'b1, pv = 1'b0, rint = 1'b0, fifo_full = 1'b0;
    logic [7:0] din = 8'h00;
    router_pkt_reg_if #(.DATA_W(8), .ADDR_W(2)) ifc ();
    assign ifc.pkt_valid   = pv;
    assign ifc.data_in     = din;
    assign ifc.fifo_full   = fifo_full;
    assign ifc.rst_int_reg = rint;
    router_pkt_reg #(.DATA_W(8), .ADDR_W(2), .HOLD_DEPTH(DEPTH)) dut (
        .clock_i (clk),
        .resetn_i(resetn),
        .bus     (ifc.slave)
    );
    always #5 clk = ~clk;
    int n_chk = 0, n_pass = 0, cyc = 0, ff_idx = 0;
    bit chk_on = 0;
    logic [63:0] ff_pat = '0, rint_mask = '0;
    logic [7:0] pkt[$], wr_log[$], m_q[$];
    int wr_cyc[$];
    bit m_load, m_drain, m_acc, m_dv, m_hv, m_pdone, m_low, m_err, m_lerr;
    logic [7:0] m_dout, m_par;
    logic [1:0] m_addr;
    int m_plen, m_len;
    logic hdr_hv, hdr_err, hdr_pdone, hdr_low, par_err, par_pdone, par_low, par_lerr, par_busy;
    logic [1:0] hdr_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_q.delete();
        {m_load, m_drain, m_acc, m_dv, m_hv, m_pdone, m_low, m_err, m_lerr} = '0;
        m_dout = 0; m_par = 0; m_addr = 0; m_plen = 0; m_len = 0;
    endtask

    // one clock edge of the spec's rules: queue holds bytes waiting for the FIFO
    task automatic model_step();
        int qs;
        bit acc, hdr, pay, par, leave;
        qs    = m_q.size();
        acc   = !(qs == DEPTH || m_drain) && (m_load || (!m_drain && pv));
        hdr   = acc && !m_load;
        pay   = acc && m_load && pv;
        par   = acc && m_load && !pv;
        leave = m_drain && qs == 0;
        m_acc = acc;
        m_hv  = hdr;
        if (fifo_full) begin
            m_dv = 0;
            if (acc) m_q.push_back(din);
        end else if (qs > 0) begin
            m_dout = m_q.pop_front();
            m_dv = 1;
            if (acc) m_q.push_back(din);
        end else begin
            m_dv = acc;
            if (acc) m_dout = din;
        end
        if (hdr) begin
            m_load = 1; m_addr = din[1:0]; m_par = din; m_pdone = 0; m_err = 0; m_lerr = 0;
            m_plen = 0; m_len = int'(din[7:2]);
        end
        if (pay) begin
            m_par = m_par ^ din;
            if (m_plen < 63) m_plen++;
        end
        if (par) begin
            m_load = 0; m_drain = 1; m_err = (m_par != din); m_pdone = 1;
            m_lerr = LEN_EN && (m_plen != m_len);
        end
        m_low = rint ? 1'b0 : par ? 1'b1 : m_low;
        if (leave) m_drain = 0;
    endtask

    task automatic cycle();
        fifo_full = (ff_idx < 64) ? ff_pat[ff_idx] : 1'b0;
        ff_idx++;
        @(posedge clk);
        if (resetn) model_step();
        cyc++;
        @(negedge clk);
    endtask

    // compare every output against the model once per cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            chk("dout_valid", ifc.dout_valid, m_dv);
            if (m_dv) chk("dout", ifc.dout, m_dout);
            chk("busy", ifc.busy, (m_q.size() == DEPTH) || m_drain);
            chk("header_valid", ifc.header_valid, m_hv);
            chk("header_addr", ifc.header_addr, m_addr);
            chk("parity_done", ifc.parity_done, m_pdone);
            chk("low_pkt_valid", ifc.low_pkt_valid, m_low);
            chk("err", ifc.err, m_err);
            chk("len_err", ifc.len_err, m_lerr);
            if (ifc.dout_valid) begin
                wr_log.push_back(ifc.dout);
                wr_cyc.push_back(cyc);
            end
        end
    end

    task automatic send();
        int g;
        for (int i = 0; i < pkt.size(); i++) begin
            pv = (i != pkt.size() - 1);
            din = pkt[i];
            rint = rint_mask[i];
            g = 0;
            do begin cycle(); g++; end while (!m_acc && g < 100);
            if (!m_acc) begin n_chk++; $display("FAIL accept_timeout: byte %0d never accepted", i); end
            if (i == 0) begin
                hdr_hv = ifc.header_valid; hdr_addr = ifc.header_addr; hdr_err = ifc.err;
                hdr_pdone = ifc.parity_done; hdr_low = ifc.low_pkt_valid;
            end
            if (i == pkt.size() - 1) begin
                par_err = ifc.err; par_pdone = ifc.parity_done; par_low = ifc.low_pkt_valid;
                par_lerr = ifc.len_err; par_busy = ifc.busy;
            end
            rint = 1'b0;
        end
        pv = 1'b0; din = 8'h00;
        g = 0;
        while ((m_drain || m_q.size() != 0) && g < 100) begin cycle(); g++; end
        if (m_drain || m_q.size() != 0) begin n_chk++; $display("FAIL drain_timeout: model still draining"); end
        cycle();
    endtask

    task automatic start_test(input logic [63:0] ffp, input logic [63:0] rm);
        ff_pat = ffp; ff_idx = 0; rint_mask = rm;
        wr_log.delete(); wr_cyc.delete();
    endtask

    initial begin
        logic [7:0] x;
        #1 resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_dout_valid", ifc.dout_valid, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_header_valid", ifc.header_valid, 0);
        chk("rst_low_pkt_valid", ifc.low_pkt_valid, 0);
        chk("rst_err", ifc.err, 0);
        model_reset();
        resetn = 1'b1;
        chk_on = 1;
        cycle();
        // good packet, FIFO always ready
        start_test(64'h0, 64'h0);
        pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        send();
        chk("t1_count", wr_log.size(), 5);
        if (wr_log.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("t1_byte", wr_log[i], pkt[i]);
            chk("t1_back_to_back", wr_cyc[4] - wr_cyc[0], 4);
        end
        chk("t1_hdr_valid", hdr_hv, 1);
        chk("t1_hdr_addr", hdr_addr, 1);
        chk("t1_parity_done", par_pdone, 1);
        chk("t1_err", par_err, 0);
        chk("t1_len_err", par_lerr, 0);
        chk("t1_low", par_low, 1);
        // bad parity, then controller soft reset of low_pkt_valid
        start_test(64'h0, 64'h0);
        pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
        send();
        chk("t2_err", par_err, 1);
        chk("t2_parity_done", par_pdone, 1);
        rint = 1'b1; cycle(); rint = 1'b0;
        chk("t2_rint_clear", ifc.low_pkt_valid, 0);
        chk("t2_err_held", ifc.err, 1);
        // FIFO full for six cycles starting at the first payload byte
        start_test(64'h7E, 64'h0);
        pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        send();
        chk("t3_hdr_clears_err", hdr_err, 0);
        chk("t3_hdr_clears_done", hdr_pdone, 0);
        chk("t3_busy_when_full", par_busy, 1);
        chk("t3_count", wr_log.size(), 5);
        if (wr_log.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("t3_byte", wr_log[i], pkt[i]);
            chk("t3_hold_gap", wr_cyc[1] - wr_cyc[0], 7);
            chk("t3_no_gaps", wr_cyc[4] - wr_cyc[1], 3);
        end
        // 20-byte packet under toggling FIFO full, soft reset coinciding with the header
        start_test(64'hAAAA_AAAA_AAAA_AAAA, 64'h1);
        pkt = '{8'h4A};
        x = 8'h4A;
        for (int i = 0; i < 18; i++) begin
            pkt.push_back(8'(i * 7 + 3));
            x = x ^ 8'(i * 7 + 3);
        end
        pkt.push_back(x);
        send();
        chk("t4_hdr_valid", hdr_hv, 1);
        chk("t4_hdr_addr", hdr_addr, 2);
        chk("t4_rint_with_hdr", hdr_low, 0);
        chk("t4_count", wr_log.size(), 20);
        if (wr_log.size() == 20)
            for (int i = 0; i < 20; i++) chk("t4_byte", wr_log[i], pkt[i]);
        chk("t4_err", par_err, 0);
        chk("t4_len_err", par_lerr, 0);
        // asynchronous reset with three payload bytes buffered
        start_test(64'hE, 64'h0);
        pv = 1'b1;
        din = 8'h0D; cycle();
        din = 8'h11; cycle();
        din = 8'h22; cycle();
        din = 8'h33; cycle();
        #2 resetn = 1'b0;
        #1;
        chk("t5_dout_valid", ifc.dout_valid, 0);
        chk("t5_dout", ifc.dout, 0);
        chk("t5_busy", ifc.busy, 0);
        chk("t5_header_valid", ifc.header_valid, 0);
        chk("t5_header_addr", ifc.header_addr, 0);
        chk("t5_parity_done", ifc.parity_done, 0);
        chk("t5_low", ifc.low_pkt_valid, 0);
        chk("t5_err", ifc.err, 0);
        model_reset();
        wr_log.delete(); wr_cyc.delete();
        din = 8'h44; cycle(); cycle();
        resetn = 1'b1; pv = 1'b0;
        repeat (3) cycle();
        chk("t5_no_writes", wr_log.size(), 0);
        // short packet (len 3, two payload bytes); soft reset wins over the parity-accept set
        start_test(64'h0, 64'h8);
        pkt = '{8'h0D, 8'h11, 8'h22, 8'h3E};
        send();
        chk("t6_len_err", par_lerr, LEN_EN);
        chk("t6_err", par_err, 0);
        chk("t6_parity_done", par_pdone, 1);
        chk("t6_rint_priority", par_low, 0);
        // pkt_valid low in IDLE starts nothing
        start_test(64'h0, 64'h0);
        pv = 1'b0; din = 8'h55;
        repeat (3) cycle();
        chk("t7_no_header", ifc.header_valid, 0);
        chk("t7_no_writes", wr_log.size(), 0);
        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
